// File: rtl/acc_out_port.sv
// Read-side port for the accumulator: captures full-word or lower-byte-merged
// values on controller strobes and queues them for a valid/ready consumer.
module acc_out_port #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ain,
  input  logic             out_write,
  input  logic             out_lower_write,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             full,
  output logic [CW-1:0]    level,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_level;
  logic [WIDTH-1:0] r_shadow;
  logic             r_overflow;

  logic             w_push_req;
  logic [WIDTH-1:0] w_push_data;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  // A full-word write takes priority; the lower-byte form keeps the shadow's
  // upper byte so the read side mirrors the accumulator's byte-load mode.
  assign w_push_req  = out_write | out_lower_write;
  assign w_push_data = out_write ? ain : {r_shadow[WIDTH-1:8], ain[7:0]};

  assign w_full = (r_level == CW'(DEPTH));
  assign w_pop  = (r_level != '0) && dout_ready;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign w_push = w_push_req && (!w_full || w_pop);
  assign w_drop = w_push_req && w_full && !w_pop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_shadow   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_req) r_shadow <= w_push_data;
      if (w_push)     r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)      r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + CW'(1);
        2'b01:   r_level <= r_level - CW'(1);
        default: r_level <= r_level;
      endcase

      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  // NOTE: storage has no reset; level and pointers define which entries are
  // live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign dout_valid = (r_level != '0);
  assign dout       = dout_valid ? r_mem[r_rd_ptr] : '0;
  assign full       = w_full;
  assign level      = r_level;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_acc_out_port.sv
// Directed bench for acc_out_port: reset, capture modes, full/overflow rules,
// backpressure with wrap, and reset in the middle of a stream.
module tb_acc_out_port;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] ain;
  logic             out_write;
  logic             out_lower_write;
  logic             ovf_clr;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             full;
  logic [CW-1:0]    level;
  logic             overflow;

  int n_vec = 0;
  int n_err = 0;

  acc_out_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .ain             (ain),
    .out_write       (out_write),
    .out_lower_write (out_lower_write),
    .ovf_clr         (ovf_clr),
    .dout            (dout),
    .dout_valid      (dout_valid),
    .dout_ready      (dout_ready),
    .full            (full),
    .level           (level),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  // Outputs settle #1 after the edge; inputs are changed at that point too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    out_write       = 1'b0;
    out_lower_write = 1'b0;
    ovf_clr         = 1'b0;
    dout_ready      = 1'b0;
    ain             = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic push_full(input logic [WIDTH-1:0] v);
    ain = v; out_write = 1'b1;
    tick();
    out_write = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    out_write = 1'b1; ain = 16'hBEEF; dout_ready = 1'b1;
    tick();
    n_vec++;
    if ({dout_valid, full, overflow, level, dout} !== {3'b000, CW'(0), 16'h0000}) begin
      n_err++;
      $display("FAIL reset: valid=%b full=%b ovf=%b level=%0d dout=%h, expected all zero",
               dout_valid, full, overflow, level, dout);
    end
    rst = 1'b1;
    idle();
  endtask

  task automatic test_basic();
    do_reset();
    push_full(16'd300);
    n_vec++;
    if (dout !== 16'h012C || dout_valid !== 1'b1 || level !== CW'(1)) begin
      n_err++;
      $display("FAIL basic_push: dout=%h valid=%b level=%0d, expected 012c 1 1", dout, dout_valid, level);
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    n_vec++;
    if (dout !== 16'h0000 || dout_valid !== 1'b0 || level !== CW'(0)) begin
      n_err++;
      $display("FAIL basic_pop: dout=%h valid=%b level=%0d, expected 0000 0 0", dout, dout_valid, level);
    end
  endtask

  task automatic test_merge();
    logic [WIDTH-1:0] exp_words [2];
    exp_words[0] = 16'h1234;
    exp_words[1] = 16'h12DE;
    do_reset();
    push_full(16'h1234);
    ain = 16'hDEDE; out_lower_write = 1'b1;
    tick();
    out_lower_write = 1'b0;
    n_vec++;
    if (level !== CW'(2)) begin
      n_err++;
      $display("FAIL merge_level: level=%0d expected 2", level);
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (dout !== exp_words[i] || dout_valid !== 1'b1) begin
        n_err++;
        $display("FAIL merge_word%0d: dout=%h valid=%b expected %h 1", i, dout, dout_valid, exp_words[i]);
      end
      tick();
    end
    dout_ready = 1'b0;
    ain = 16'hABCD; out_write = 1'b1; out_lower_write = 1'b1;
    tick();
    out_write = 1'b0; out_lower_write = 1'b0;
    n_vec++;
    if (level !== CW'(1) || dout !== 16'hABCD) begin
      n_err++;
      $display("FAIL both_strobes: level=%0d dout=%h expected 1 abcd", level, dout);
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    n_vec++;
    if (level !== CW'(0)) begin
      n_err++;
      $display("FAIL both_strobes_drain: level=%0d expected 0", level);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) push_full(WIDTH'(i));
    n_vec++;
    if (full !== 1'b1 || level !== CW'(4) || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL fill: full=%b level=%0d ovf=%b expected 1 4 0", full, level, overflow);
    end
    push_full(16'd5);
    n_vec++;
    if (overflow !== 1'b1 || level !== CW'(4) || dout !== 16'd1) begin
      n_err++;
      $display("FAIL drop: ovf=%b level=%0d head=%h expected 1 4 0001", overflow, level, dout);
    end
    dout_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_vec++;
      if (dout !== WIDTH'(i) || dout_valid !== 1'b1) begin
        n_err++;
        $display("FAIL drain%0d: dout=%h valid=%b expected %h 1", i, dout, dout_valid, WIDTH'(i));
      end
      tick();
    end
    dout_ready = 1'b0;
    n_vec++;
    if (dout_valid !== 1'b0 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL drain_empty: valid=%b ovf=%b expected 0 1", dout_valid, overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr: ovf=%b expected 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [WIDTH-1:0] exp_words [4];
    exp_words[0] = 16'd2; exp_words[1] = 16'd3;
    exp_words[2] = 16'd4; exp_words[3] = 16'd9;
    do_reset();
    for (int i = 1; i <= 4; i++) push_full(WIDTH'(i));
    ain = 16'd9; out_write = 1'b1; dout_ready = 1'b1;
    tick();
    out_write = 1'b0; dout_ready = 1'b0;
    n_vec++;
    if (level !== CW'(4) || full !== 1'b1 || dout !== 16'd2 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL full_pushpop: level=%0d full=%b dout=%h ovf=%b expected 4 1 0002 0",
               level, full, dout, overflow);
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (dout !== exp_words[i]) begin
        n_err++;
        $display("FAIL full_pushpop_drain%0d: dout=%h expected %h", i, dout, exp_words[i]);
      end
      tick();
    end
    dout_ready = 1'b0;
    n_vec++;
    if (dout_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL full_pushpop_end: valid=%b ovf=%b expected 0 0", dout_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] held;
    logic             was_stalled;
    int               pushed  = 0;
    int               popped  = 0;
    int               cycles  = 0;
    do_reset();
    was_stalled = 1'b0;
    held        = '0;
    while (popped < 20 && cycles < 500) begin
      if (was_stalled) begin
        n_vec++;
        if (dout_valid !== 1'b1 || dout !== held) begin
          n_err++;
          $display("FAIL bp_hold: dout=%h valid=%b expected %h 1", dout, dout_valid, held);
        end
      end
      dout_ready = 1'($urandom_range(0, 1));
      out_write  = (pushed < 20) && (q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      ain        = 16'hC000 + WIDTH'(pushed * 7);
      if (dout_valid && dout_ready) begin
        n_vec++;
        if (q.size() == 0 || dout !== q[0]) begin
          n_err++;
          $display("FAIL bp_order%0d: dout=%h expected %h", popped, dout,
                   (q.size() != 0) ? q[0] : 16'hxxxx);
        end
        if (q.size() != 0) void'(q.pop_front());
        popped++;
      end
      if (out_write) begin
        q.push_back(ain);
        pushed++;
      end
      was_stalled = dout_valid && !dout_ready;
      held        = dout;
      tick();
      cycles++;
      n_vec++;
      if (level !== CW'(q.size())) begin
        n_err++;
        $display("FAIL bp_level: level=%0d expected %0d", level, q.size());
      end
    end
    idle();
    n_vec++;
    if (popped != 20 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL bp_done: popped=%0d ovf=%b expected 20 0 within budget", popped, overflow);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    push_full(16'hA1B2);
    push_full(16'hC3D4);
    push_full(16'hE5F6);
    n_vec++;
    if (level !== CW'(3)) begin
      n_err++;
      $display("FAIL midrst_pre: level=%0d expected 3", level);
    end
    rst = 1'b0; dout_ready = 1'b1;
    tick();
    rst = 1'b1; dout_ready = 1'b0;
    n_vec++;
    if (level !== CW'(0) || dout_valid !== 1'b0 || overflow !== 1'b0 || dout !== 16'h0000) begin
      n_err++;
      $display("FAIL midrst: level=%0d valid=%b ovf=%b dout=%h expected 0 0 0 0000",
               level, dout_valid, overflow, dout);
    end
    ain = 16'h00FF; out_lower_write = 1'b1;
    tick();
    out_lower_write = 1'b0;
    n_vec++;
    if (dout !== 16'h00FF || level !== CW'(1)) begin
      n_err++;
      $display("FAIL midrst_shadow: dout=%h level=%0d expected 00ff 1", dout, level);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    #2;
    test_reset();
    test_basic();
    test_merge();
    test_fill_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
